// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first: synchronises RXD, qualifies the start bit at mid-bit,
// samples data and stop bits at mid-bit, and reports a good byte or a framing error.
module uart_recv #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BIT_END  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_END = 16'(BPS_CNT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        rx_s0;
  logic        rx_s1;
  logic        rx_s2;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        fall;

  assign fall = rx_s2 & ~rx_s1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      rx_s0     <= 1'b1;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      clk_cnt   <= 16'd0;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      uart_data <= 8'h00;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_s0     <= uart_rxd;
      rx_s1     <= rx_s0;
      rx_s2     <= rx_s1;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
      clk_cnt   <= clk_cnt + 16'd1;

      case (state)
        IDLE: begin
          // busy stays high through the done cycle, then drops unless a new frame starts
          rx_busy <= fall;
          if (fall) begin
            state   <= START;
            clk_cnt <= 16'd0;
          end
        end

        START: begin
          if (clk_cnt == HALF_END) begin
            clk_cnt <= 16'd0;
            if (!rx_s1) begin
              state   <= DATA;
              bit_cnt <= 4'd0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
        end

        DATA: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt               <= 16'd0;
            shift[bit_cnt[2:0]]   <= rx_s1;
            bit_cnt               <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= 16'd0;
            if (rx_s1) begin
              uart_data <= shift;
              uart_done <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end

        BREAK: begin
          // a held-low line must return high before another start bit can be seen
          if (rx_s1) begin
            state   <= IDLE;
            clk_cnt <= 16'd0;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: a bit-accurate serial transmitter drives RXD, and expected bytes,
// pulse cycles and busy windows come from frame arithmetic relative to the start-bit edge.
module tb_uart_recv;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  // driving cycle -> fall cycle (2 sync flops) -> mid start -> 9 bits -> registered pulse
  localparam int DONE_LAT = 2 + BPS / 2 + 9 * BPS + 1;
  localparam int LOG_LEN  = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       err;
  logic       busy;

  uart_recv #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .uart_rxd (rxd),
    .uart_data(data),
    .uart_done(done),
    .frame_err(err),
    .rx_busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         done_cyc[$];
  logic [7:0] done_dat[$];
  int         err_cyc[$];
  int         both_cnt = 0;
  logic       busy_log[LOG_LEN];

  always @(negedge clk) begin
    if (cyc < LOG_LEN) busy_log[cyc] = busy;
    if (done) begin
      done_cyc.push_back(cyc);
      done_dat.push_back(data);
    end
    if (err) err_cyc.push_back(cyc);
    if (done && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dcyc(input int i);
    return (i < done_cyc.size()) ? 32'(done_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ddat(input int i);
    return (i < done_dat.size()) ? 32'(done_dat[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ecyc(input int i);
    return (i < err_cyc.size()) ? 32'(err_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] blog(input int i);
    return (i >= 0 && i < LOG_LEN) ? 32'(busy_log[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_bit(input logic v);
    rxd = v;
    repeat (BPS) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    tx_bit(stop);
  endtask

  initial begin
    int         k;
    int         h;
    int         b0;
    int         e0;
    logic [9:0] fr;
    int         ks[16];
    logic [7:0] bs[16];

    // reset
    repeat (3) tick();
    @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err",  32'(err),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    repeat (20) tick();

    // single good frame with exact timing and busy window
    b0 = done_cyc.size(); e0 = err_cyc.size(); k = cyc;
    send(8'hA5, 1'b1);
    repeat (5) tick();
    chk("t1_done_count", done_cyc.size() - b0, 1);
    chk("t1_done_cycle", dcyc(b0) - k, DONE_LAT);
    chk("t1_done_data",  ddat(b0), 32'hA5);
    chk("t1_err_count",  err_cyc.size() - e0, 0);
    chk("t1_busy_at_E",  blog(k + 2), 0);
    chk("t1_busy_E+1",   blog(k + 3), 1);
    chk("t1_busy_E+96",  blog(k + 98), 1);
    chk("t1_busy_E+97",  blog(k + 99), 0);
    chk("t1_data_hold",  32'(data), 32'hA5);

    // short low glitch, then a real frame
    b0 = done_cyc.size(); e0 = err_cyc.size(); k = cyc;
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (20) tick();
    chk("t2_busy_E+5",   blog(k + 2 + BPS / 2), 1);
    chk("t2_busy_E+6",   blog(k + 3 + BPS / 2), 0);
    chk("t2_done_count", done_cyc.size() - b0, 0);
    chk("t2_err_count",  err_cyc.size() - e0, 0);
    b0 = done_cyc.size(); k = cyc;
    send(8'h3C, 1'b1);
    repeat (5) tick();
    chk("t2_next_count", done_cyc.size() - b0, 1);
    chk("t2_next_cycle", dcyc(b0) - k, DONE_LAT);
    chk("t2_next_data",  ddat(b0), 32'h3C);

    // framing error followed by a held-low line
    b0 = done_cyc.size(); e0 = err_cyc.size(); k = cyc;
    send(8'h5A, 1'b0);
    repeat (20) tick();
    h = cyc;
    rxd = 1'b1;
    repeat (10) tick();
    chk("t3_err_count",   err_cyc.size() - e0, 1);
    chk("t3_err_cycle",   ecyc(e0) - k, DONE_LAT);
    chk("t3_done_count",  done_cyc.size() - b0, 0);
    chk("t3_data_kept",   32'(data), 32'h3C);
    chk("t3_busy_break",  blog(h + 2), 1);
    chk("t3_busy_idle",   blog(h + 3), 0);

    // back-to-back frames with no idle gap
    b0 = done_cyc.size(); e0 = err_cyc.size(); k = cyc;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h81, 1'b1);
    repeat (5) tick();
    chk("t4_done_count", done_cyc.size() - b0, 3);
    chk("t4_cycle0", dcyc(b0)     - k, DONE_LAT);
    chk("t4_cycle1", dcyc(b0 + 1) - k, DONE_LAT + 10 * BPS);
    chk("t4_cycle2", dcyc(b0 + 2) - k, DONE_LAT + 20 * BPS);
    chk("t4_data0",  ddat(b0),     32'h00);
    chk("t4_data1",  ddat(b0 + 1), 32'hFF);
    chk("t4_data2",  ddat(b0 + 2), 32'h81);
    chk("t4_err_count", err_cyc.size() - e0, 0);

    // reset pulse during data bit 4 of 0xC3
    b0 = done_cyc.size(); e0 = err_cyc.size();
    fr = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      if (i == 5) begin
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_data", 32'(data), 32'h00);
        chk("t5_rst_done", 32'(done), 32'h0);
        chk("t5_rst_err",  32'(err),  32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        tick();
        repeat (BPS - 6) tick();
      end else begin
        repeat (BPS) tick();
      end
    end
    chk("t5_done_count", done_cyc.size() - b0, 0);
    chk("t5_err_count",  err_cyc.size() - e0, 0);
    repeat (12 * BPS) tick();
    b0 = done_cyc.size(); k = cyc;
    send(8'h12, 1'b1);
    repeat (5) tick();
    chk("t5_next_count", done_cyc.size() - b0, 1);
    chk("t5_next_cycle", dcyc(b0) - k, DONE_LAT);
    chk("t5_next_data",  32'(data), 32'h12);

    // random loopback stream with small random gaps
    b0 = done_cyc.size(); e0 = err_cyc.size();
    for (int i = 0; i < 16; i++) begin
      bs[i] = 8'($urandom_range(0, 255));
      ks[i] = cyc;
      send(bs[i], 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (5) tick();
    chk("t6_done_count", done_cyc.size() - b0, 16);
    chk("t6_err_count",  err_cyc.size() - e0, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t6_data%0d", i),  ddat(b0 + i), 32'(bs[i]));
      chk($sformatf("t6_cycle%0d", i), dcyc(b0 + i) - ks[i], DONE_LAT);
    end

    chk("done_err_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
